deser7: RTL and testbench

- Serial-to-parallel receiver that sits directly downstream of the 7-bit parallel-load shift stage.
- Consumes its LSB-first serial bit stream and reassembles WIDTH-bit words.
- Delivers each completed word with a one-cycle valid pulse for a downstream parallel consumer, such as a display or compare stage.
- Frame alignment comes from an explicit start marker. Mid-frame restarts are detected and flagged.

---
 rtl/deser7.sv | 98 +++++++++
 tb/tb_deser7.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/deser7.sv
// LSB-first serial-to-parallel receiver. It assembles WIDTH-bit frames that begin at an explicit
// start marker, and it flags any partial frame that a new start marker aborts.
module deser7 #(
    parameter int WIDTH = 7,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;

    assign shifted   = {din, shreg_q[WIDTH-1:1]};
    assign first_bit = {din, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (din_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_d = first_bit;
                        cnt_d   = CW'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (start) begin
                        // A new marker wins over the partial frame, which is dropped.
                        frame_err_d = 1'b1;
                        shreg_d     = first_bit;
                        cnt_d       = CW'(1);
                    end else if (cnt_q == LAST) begin
                        shreg_d      = shifted;
                        dout_d       = shifted;
                        dout_valid_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == RECV);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_deser7.sv
// Randomized and directed bench for deser7. A queue-based frame model predicts
// dout, dout_valid, busy and frame_err on every cycle.
module tb_deser7;

    localparam int WIDTH = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             din_en = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;

    deser7 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // Reference model: the bits of the current frame, held in a queue.
    bit               m_q[$];
    logic             m_in_frame = 1'b0;
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_valid = 1'b0;
    logic             m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic s, input logic d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_q.delete();
            m_in_frame = 1'b0;
            m_dout     = '0;
        end else if (e) begin
            if (s) begin
                if (m_in_frame) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_q.push_back(d);
                if (m_q.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) m_dout[i] = m_q[i];
                    m_valid    = 1'b1;
                    m_in_frame = 1'b0;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic d);
        rst    = r;
        din_en = e;
        start  = s;
        din    = d;
        @(posedge clk);
        model(r, e, s, d);
        #1;
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_in_frame));
        check("frame_err", 32'(frame_err), 32'(m_err));
        if (dout_valid) n_valid++;
        if (frame_err) n_err++;
    endtask

    task automatic gap(input int n);
        for (int g = 0; g < n; g++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input int gaps);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) gap(gaps);
            step(1'b0, 1'b1, (i == 0), w[i]);
        end
    endtask

    int v0;
    int e0;

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Continuous strobes: a single valid pulse
        v0 = n_valid;
        send_bits(7'h55, WIDTH, 0);
        check("h55_word", 32'(dout), 32'h55);
        check("h55_valid", 32'(dout_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("h55_pulses", 32'(n_valid - v0), 32'd1);

        // Strobe on every third cycle
        v0 = n_valid;
        send_bits(7'h4B, WIDTH, 2);
        gap(3);
        check("h4B_word", 32'(dout), 32'h4B);
        check("h4B_pulses", 32'(n_valid - v0), 32'd1);

        // Back-to-back frames with no bubble
        v0 = n_valid;
        send_bits(7'h01, WIDTH, 0);
        check("b2b_first", 32'(dout), 32'h01);
        send_bits(7'h7E, WIDTH, 0);
        check("b2b_second", 32'(dout), 32'h7E);
        check("b2b_pulses", 32'(n_valid - v0), 32'd2);

        // A new start marker aborts a partial frame
        v0 = n_valid;
        e0 = n_err;
        send_bits(7'h12, 3, 0);
        send_bits(7'h33, WIDTH, 0);
        gap(1);
        check("abort_word", 32'(dout), 32'h33);
        check("abort_pulses", 32'(n_valid - v0), 32'd1);
        check("abort_errs", 32'(n_err - e0), 32'd1);

        // Reset in mid-frame, then bits without a start marker while idle
        e0 = n_err;
        send_bits(7'h15, 4, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_dout", 32'(dout), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
        check("idle_busy", 32'(busy), 32'h0);
        send_bits(7'h2A, WIDTH, 0);
        check("rst_word", 32'(dout), 32'h2A);
        check("rst_errs", 32'(n_err - e0), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
